// File: rtl/l2_mem_bridge.sv
// Bridges full-line L2 memory requests onto a narrow external bus: one command
// followed by LINE_BITS/BEAT_BITS data beats, one line transaction at a time.
module l2_mem_bridge #(
   parameter int ADDR_WIDTH = 64,
   parameter int LINE_BITS  = 128,
   parameter int BEAT_BITS  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_req_valid,
   input  logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic [LINE_BITS-1:0]  mem_req_store_data,
   input  logic [3:0]            mem_req_opcode,
   output logic                  mem_rsp_valid,
   output logic [LINE_BITS-1:0]  mem_rsp_load_data,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ready,
   output logic [ADDR_WIDTH-1:0] bus_req_addr,
   output logic                  bus_req_write,
   output logic                  bus_wdata_valid,
   input  logic                  bus_wdata_ready,
   output logic [BEAT_BITS-1:0]  bus_wdata,
   input  logic                  bus_wack,
   input  logic                  bus_rdata_valid,
   input  logic [BEAT_BITS-1:0]  bus_rdata,
   output logic                  busy,
   output logic                  err
);

   localparam int BEATS       = LINE_BITS / BEAT_BITS;
   localparam int CNT_W       = $clog2(BEATS);
   localparam int IDX_W       = $clog2(LINE_BITS);
   localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

   localparam logic [3:0]            OP_READ   = 4'd4;
   localparam logic [3:0]            OP_WRITE  = 4'd7;
   localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

   typedef enum logic [2:0] {IDLE, CMD, WDATA, WACK, RDATA, RESP} state_t;

   state_t               state;
   logic [CNT_W-1:0]     beat_cnt;
   logic [CNT_W-1:0]     cnt_next;
   logic [IDX_W-1:0]     beat_base;
   logic [IDX_W-1:0]     next_base;
   logic [LINE_BITS-1:0] store_q;
   logic                 stray_beat;

   assign cnt_next  = beat_cnt + 1'b1;
   assign beat_base = IDX_W'(int'(beat_cnt) * BEAT_BITS);
   assign next_base = IDX_W'(int'(cnt_next) * BEAT_BITS);
   assign busy      = (state != IDLE);

   // Bus events the current state does not expect; they are dropped and flagged.
   assign stray_beat = (bus_rdata_valid && (state != RDATA)) ||
                       (bus_wack && (state != WACK));

   // NOTE: store_q is pure datapath and is always loaded in IDLE before any
   // beat is driven from it, so it carries no reset.
   always_ff @(posedge clk) begin
      if ((state == IDLE) && mem_req_valid) begin
         store_q <= mem_req_store_data;
      end
   end

   // NOTE: every flop here uses <= so all state updates see the pre-edge
   // values; the case default keeps an illegal encoding from locking up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         beat_cnt          <= '0;
         bus_req_valid     <= 1'b0;
         bus_req_addr      <= '0;
         bus_req_write     <= 1'b0;
         bus_wdata_valid   <= 1'b0;
         bus_wdata         <= '0;
         mem_rsp_valid     <= 1'b0;
         mem_rsp_load_data <= '0;
         err               <= 1'b0;
      end else begin
         mem_rsp_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (mem_req_valid) begin
                  bus_req_addr <= mem_req_addr & LINE_MASK;
                  beat_cnt     <= '0;
                  if ((mem_req_opcode == OP_READ) || (mem_req_opcode == OP_WRITE)) begin
                     bus_req_write <= (mem_req_opcode == OP_WRITE);
                     bus_req_valid <= 1'b1;
                     state         <= CMD;
                  end else begin
                     err               <= 1'b1;
                     mem_rsp_load_data <= '0;
                     mem_rsp_valid     <= 1'b1;
                     state             <= RESP;
                  end
               end
            end

            CMD: begin
               if (bus_req_ready) begin
                  bus_req_valid <= 1'b0;
                  if (bus_req_write) begin
                     bus_wdata_valid <= 1'b1;
                     bus_wdata       <= store_q[BEAT_BITS-1:0];
                     state           <= WDATA;
                  end else begin
                     state <= RDATA;
                  end
               end
            end

            WDATA: begin
               if (bus_wdata_ready) begin
                  if (beat_cnt == LAST_BEAT) begin
                     bus_wdata_valid <= 1'b0;
                     state           <= WACK;
                  end else begin
                     beat_cnt  <= cnt_next;
                     bus_wdata <= store_q[next_base +: BEAT_BITS];
                  end
               end
            end

            WACK: begin
               if (bus_wack) begin
                  mem_rsp_valid <= 1'b1;
                  state         <= RESP;
               end
            end

            RDATA: begin
               if (bus_rdata_valid) begin
                  mem_rsp_load_data[beat_base +: BEAT_BITS] <= bus_rdata;
                  beat_cnt <= cnt_next;
                  if (beat_cnt == LAST_BEAT) begin
                     mem_rsp_valid <= 1'b1;
                     state         <= RESP;
                  end
               end
            end

            RESP: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase

         if (stray_beat) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_l2_mem_bridge.sv
// Directed bench for l2_mem_bridge: stimulus pushes expected responses into a
// scoreboard queue that a negedge monitor drains whenever mem_rsp_valid fires.
module tb_l2_mem_bridge;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         mem_req_valid = 1'b0;
   logic [63:0]  mem_req_addr = '0;
   logic [127:0] mem_req_store_data = '0;
   logic [3:0]   mem_req_opcode = '0;
   logic         mem_rsp_valid;
   logic [127:0] mem_rsp_load_data;
   logic         bus_req_valid;
   logic         bus_req_ready = 1'b0;
   logic [63:0]  bus_req_addr;
   logic         bus_req_write;
   logic         bus_wdata_valid;
   logic         bus_wdata_ready = 1'b0;
   logic [31:0]  bus_wdata;
   logic         bus_wack = 1'b0;
   logic         bus_rdata_valid = 1'b0;
   logic [31:0]  bus_rdata = '0;
   logic         busy;
   logic         err;

   l2_mem_bridge #(
      .ADDR_WIDTH (64),
      .LINE_BITS  (128),
      .BEAT_BITS  (32)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .mem_req_valid      (mem_req_valid),
      .mem_req_addr       (mem_req_addr),
      .mem_req_store_data (mem_req_store_data),
      .mem_req_opcode     (mem_req_opcode),
      .mem_rsp_valid      (mem_rsp_valid),
      .mem_rsp_load_data  (mem_rsp_load_data),
      .bus_req_valid      (bus_req_valid),
      .bus_req_ready      (bus_req_ready),
      .bus_req_addr       (bus_req_addr),
      .bus_req_write      (bus_req_write),
      .bus_wdata_valid    (bus_wdata_valid),
      .bus_wdata_ready    (bus_wdata_ready),
      .bus_wdata          (bus_wdata),
      .bus_wack           (bus_wack),
      .bus_rdata_valid    (bus_rdata_valid),
      .bus_rdata          (bus_rdata),
      .busy               (busy),
      .err                (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      logic         err;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   localparam logic [3:0] OP_RD = 4'd4;
   localparam logic [3:0] OP_WR = 4'd7;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] beat_of(input logic [127:0] line, input int i);
      logic [127:0] s;
      s = line >> (32 * i);
      return s[31:0];
   endfunction

   // Scoreboard monitor: every response must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && mem_rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rsp: got mem_rsp_valid=1 at cycle %0d, required 0", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_data", mem_rsp_load_data, mon_e.data);
            check("rsp_err", err, mon_e.err);
            check("rsp_cycle", cyc, mon_e.cyc);
         end
      end
   end

   // Drive a request in the current cycle; optionally expect a response lat cycles later.
   task automatic issue(input logic [3:0] op, input logic [63:0] addr, input logic [127:0] data,
                        input bit push, input logic [127:0] exp_data, input logic exp_err,
                        input int lat);
      exp_t e;
      mem_req_valid      = 1'b1;
      mem_req_opcode     = op;
      mem_req_addr       = addr;
      mem_req_store_data = data;
      if (push) begin
         e.data = exp_data;
         e.err  = exp_err;
         e.cyc  = cyc + lat;
         exp_q.push_back(e);
      end
   endtask

   // Called in the first CMD cycle; accepts the command after `stalls` wait cycles.
   task automatic do_cmd(input logic [63:0] exp_addr, input logic exp_write, input int stalls);
      for (int s = 0; s <= stalls; s++) begin
         bus_req_ready = (s == stalls);
         check("cmd_valid", bus_req_valid, 1'b1);
         check("cmd_addr", bus_req_addr, exp_addr);
         check("cmd_write", bus_req_write, exp_write);
         tick();
      end
      bus_req_ready = 1'b0;
      check("cmd_dropped", bus_req_valid, 1'b0);
   endtask

   task automatic do_read(input logic [127:0] line, input int gap_after);
      for (int i = 0; i < 4; i++) begin
         bus_rdata_valid = 1'b1;
         bus_rdata       = beat_of(line, i);
         tick();
         if (i == gap_after) begin
            bus_rdata_valid = 1'b0;
            tick();
         end
      end
      bus_rdata_valid = 1'b0;
   endtask

   task automatic do_write(input logic [127:0] line, input bit toggle);
      int idx;
      int k;
      idx = 0;
      k   = 0;
      while (idx < 4 && k < 32) begin
         bus_wdata_ready = toggle ? (k % 2 == 0) : 1'b1;
         check("wdata_valid", bus_wdata_valid, 1'b1);
         check("wdata_beat", bus_wdata, beat_of(line, idx));
         tick();
         if (bus_wdata_ready) idx++;
         k++;
      end
      bus_wdata_ready = 1'b0;
      check("wdata_done", bus_wdata_valid, 1'b0);
   endtask

   task automatic wait_rsp();
      int budget;
      budget = 30;
      while (!mem_rsp_valid && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL rsp_timeout: got no mem_rsp_valid within 30 cycles, required a response");
      end
      mem_req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #23;
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_rsp_valid", mem_rsp_valid, 1'b0);
      check("rst_load_data", mem_rsp_load_data, 128'h0);
      check("rst_req_valid", bus_req_valid, 1'b0);
      check("rst_wdata_valid", bus_wdata_valid, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();

      // Zero-wait read with an unaligned address
      issue(OP_RD, 64'h1000_0014, 128'h0, 1'b1,
            128'h44444444_33333333_22222222_11111111, 1'b0, 6);
      tick();
      check("rd_busy", busy, 1'b1);
      do_cmd(64'h1000_0010, 1'b0, 0);
      do_read(128'h44444444_33333333_22222222_11111111, -1);
      wait_rsp();
      tick();
      check("rd_idle", busy, 1'b0);

      // Write: one command stall, wdata_ready toggling, one idle WACK cycle
      issue(OP_WR, 64'h2000_0008, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1,
            128'h44444444_33333333_22222222_11111111, 1'b0, 12);
      tick();
      do_cmd(64'h2000_0000, 1'b1, 1);
      do_write(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1);
      check("wack_busy", busy, 1'b1);
      tick();
      bus_wack = 1'b1;
      tick();
      bus_wack = 1'b0;
      wait_rsp();
      tick();

      // Unsupported opcode: immediate response, no bus command, sticky err
      issue(4'd3, 64'h5000_0000, 128'h0, 1'b1, 128'h0, 1'b1, 1);
      tick();
      check("badop_no_cmd", bus_req_valid, 1'b0);
      wait_rsp();
      tick();
      check("badop_idle", busy, 1'b0);
      check("badop_no_cmd2", bus_req_valid, 1'b0);
      tick();
      check("badop_err_sticky", err, 1'b1);

      // Reset after the second read beat abandons the read
      issue(OP_RD, 64'h3000_0047, 128'h0, 1'b0, 128'h0, 1'b0, 0);
      tick();
      do_cmd(64'h3000_0040, 1'b0, 0);
      bus_rdata_valid = 1'b1;
      bus_rdata = 32'h55555555;
      tick();
      bus_rdata = 32'h66666666;
      tick();
      bus_rdata_valid = 1'b0;
      check("mid_busy", busy, 1'b1);
      #2 reset = 1'b1;
      mem_req_valid = 1'b0;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_err", err, 1'b0);
      check("arst_load_data", mem_rsp_load_data, 128'h0);
      check("arst_req_addr", bus_req_addr, 64'h0);
      check("arst_rsp_valid", mem_rsp_valid, 1'b0);
      @(posedge clk);
      #1 reset = 1'b0;
      tick();
      tick();
      check("post_rst_idle", busy, 1'b0);

      // Read after reset with a one-cycle gap in the returned beats
      issue(OP_RD, 64'h3000_0040, 128'h0, 1'b1,
            128'hAAAAAAAA_99999999_88888888_77777777, 1'b0, 7);
      tick();
      do_cmd(64'h3000_0040, 1'b0, 0);
      do_read(128'hAAAAAAAA_99999999_88888888_77777777, 1);
      wait_rsp();
      tick();

      // Back-to-back write then read, with a stray read beat in the IDLE cycle
      issue(OP_WR, 64'h0000_4000, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b1,
            128'hAAAAAAAA_99999999_88888888_77777777, 1'b0, 7);
      tick();
      do_cmd(64'h0000_4000, 1'b1, 0);
      do_write(128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b0);
      bus_wack = 1'b1;
      tick();
      bus_wack = 1'b0;
      wait_rsp();
      tick();
      issue(OP_RD, 64'h0000_402C, 128'h0, 1'b1,
            128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0, 1'b1, 6);
      bus_rdata_valid = 1'b1;
      bus_rdata = 32'hDEADBEEF;
      tick();
      bus_rdata_valid = 1'b0;
      check("stray_err", err, 1'b1);
      check("stray_no_corrupt", mem_rsp_load_data, 128'hAAAAAAAA_99999999_88888888_77777777);
      do_cmd(64'h0000_4020, 1'b0, 0);
      do_read(128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0, -1);
      wait_rsp();
      tick();
      tick();
      check("load_data_stable", mem_rsp_load_data, 128'h0BADF00D_CAFEBABE_12345678_9ABCDEF0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
